zigzag_rle_encoder: RTL and testbench
=====================================

// Module: zigzag_rle_encoder
// PURPOSE
//  Consumes one quantized 8x8 block (64 x Q16.16 coefficients from quantize_array), rounds each to a
//  saturated signed integer, scans it in JPEG zigzag order and serialises it as run-length symbols
//  (DC, AC run/value pairs, ZRL, EOB) toward the Huffman stage. One symbol per cycle, valid/ready handshakes.
// PARAMETERS
//  DATA_WIDTH   32  width of one input coefficient (Q16.16, two's complement)
//  PIXEL_COUNT  64  coefficients per block; fixed 64 (zigzag table is 8x8)
//  VAL_WIDTH    12  output value width; saturation range is +/-(2^(VAL_WIDTH-1)-1)
// PORTS
//  clk        in   1                      clock, rising edge
//  rst_n      in   1                      asynchronous active-low reset
//  in_valid   in   1                      in_coeffs holds a block
//  in_ready   out  1                      block accepted on in_valid && in_ready
//  in_coeffs  in   DATA_WIDTH*PIXEL_COUNT raster order; coef i at [i*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  1                      symbol presented
//  out_ready  in   1                      symbol consumed on out_valid && out_ready
//  out_run    out  4                      zero run before value (0..15)
//  out_value  out  VAL_WIDTH              signed coefficient value (0 for ZRL/EOB)
//  out_is_dc  out  1                      symbol is the DC term
//  out_last   out  1                      final symbol of block
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; out_run=0; out_value=0; out_is_dc=0; out_last=0;
//   block buffer, scan index and run counter cleared. Reset mid-block discards the block entirely.
//  Conversion at capture: v = (x + 32'h0000_8000) >>> 16 (round half toward +inf), then saturate
//   to [-2047, 2047] for VAL_WIDTH=12. Stored as 64 x VAL_WIDTH registers.
//  Zigzag: scan index k=0..63 reads raster entry ZZ[k]; ZZ = 0,1,8,16,9,2,3,10,17,24,... ,55,62,63
//   (standard JPEG table, constant ROM).
//  States:
//   IDLE  in_ready=1. Handshake -> capture converted block, k=0, run=0, go DC. in_ready=0 in all other states.
//   DC    present {run=0, value=blk[ZZ[0]], is_dc=1, last=0}; on out handshake k=1 -> AC.
//   AC    per cycle with no symbol pending, examine c=blk[ZZ[k]]:
//         c==0 & k<63: run++, k++ (no symbol, one cycle).
//         c!=0 & run>=16: present ZRL {15,0}; on handshake run-=16, k unchanged.
//         c!=0 & run<16: present {run,c}, last=(k==63); on handshake run=0, k++;
//          if k was 63 -> IDLE.
//         c==0 & k==63: present EOB {0,0,last=1}; on handshake -> IDLE.
//   ZRL never emitted when only zeros follow; trailing zeros collapse into single EOB.
//  Output stage registered: symbol fields stable and out_valid held high while out_ready=0.
//   out_valid drops the cycle after the last handshake unless a new symbol follows.
//  Throughput: 1 capture cycle + 1 cycle per scanned index + 1 per ZRL; zero-bubble with out_ready=1.
//  Next block accepted only after return to IDLE (no overlap); in_valid while busy is ignored.
// TESTING
//  1. All-zero block -> DC{0,0,is_dc=1}, then EOB{0,0,last=1}; exactly 2 symbols.
//  2. raster0=0x00050000, raster1=0xFFFD0000, rest 0 -> DC 5; {0,-3}; EOB last.
//  3. DC=0, only raster63=0x00010000 -> DC 0; 3x ZRL{15,0}; {14,1,last=1}; no EOB.
//  4. Rounding/saturation: 0x00018000->2, 0xFFFF8000->0, 0xFFFE8000->-1, 0x0FFF0000->2047, 0xF0000000->-2047.
//  5. Backpressure: random out_ready 30% duty on test 2/3 blocks -> identical symbol sequence, fields stable while stalled.
//  6. rst_n low during AC of block 3 -> outputs at reset values immediately; next block encodes correctly.

Source files
------------

// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder: rounds and saturates one 8x8 block of Q16.16 coefficients, scans it in JPEG
// zigzag order and emits DC / AC run-value / ZRL / EOB symbols, one per cycle.
//  clk        in   clock, rising edge
//  rst_n      in   asynchronous active-low reset; discards any block in progress
//  in_valid   in   in_coeffs holds a block
//  in_ready   out  high only in IDLE; block captured on in_valid && in_ready
//  in_coeffs  in   64 raster-order coefficients, coef i at [i*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  registered symbol valid, held while out_ready is low
//  out_ready  in   symbol consumed on out_valid && out_ready
//  out_run    out  zero run preceding out_value (15 for ZRL)
//  out_value  out  signed coefficient (0 for ZRL/EOB)
//  out_is_dc  out  symbol is the DC term
//  out_last   out  final symbol of the block
module zigzag_rle_encoder #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIXEL_COUNT = 64,
    parameter int VAL_WIDTH   = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] in_coeffs,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [3:0]                        out_run,
    output logic [VAL_WIDTH-1:0]              out_value,
    output logic                              out_is_dc,
    output logic                              out_last
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] AC    = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic signed [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(2 ** (VAL_WIDTH - 1) - 1);

    // Walks the 8x8 anti-diagonals: even diagonals move up-right, odd ones down-left,
    // turning at the block edges. Yields the standard JPEG table 0,1,8,16,9,2,...,62,63.
    function automatic logic [63:0][5:0] zz_table();
        logic [63:0][5:0] t;
        int r;
        int c;
        r = 0;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            t[i] = 6'(r * 8 + c);
            if ((r + c) % 2 == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
        return t;
    endfunction

    localparam logic [63:0][5:0] ZZ = zz_table();

    // Round half toward +inf, then clamp symmetrically so -2^(VAL_WIDTH-1) never appears.
    function automatic logic [VAL_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] r;
        r = $signed(x + DATA_WIDTH'(32'h0000_8000)) >>> 16;
        return r > MAX_V ? VAL_WIDTH'(MAX_V) : r < -MAX_V ? VAL_WIDTH'(-MAX_V) : r[VAL_WIDTH-1:0];
    endfunction

    logic [1:0]           state;
    logic [5:0]           k;
    logic [5:0]           run;
    logic [VAL_WIDTH-1:0] blk [PIXEL_COUNT];
    logic [VAL_WIDTH-1:0] cur;
    logic                 adv;

    assign in_ready = state == IDLE;
    assign cur      = blk[ZZ[k]];
    // The output register can take a new symbol when empty or being consumed this cycle.
    assign adv      = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            run       <= '0;
            out_valid <= 1'b0;
            out_run   <= '0;
            out_value <= '0;
            out_is_dc <= 1'b0;
            out_last  <= 1'b0;
            for (int i = 0; i < PIXEL_COUNT; i++) blk[i] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < PIXEL_COUNT; i++) blk[i] <= conv(in_coeffs[i*DATA_WIDTH +: DATA_WIDTH]);
                    // DC symbol is loaded straight from the capture path so the scan starts at k=1.
                    out_valid <= 1'b1;
                    out_run   <= '0;
                    out_value <= conv(in_coeffs[0 +: DATA_WIDTH]);
                    out_is_dc <= 1'b1;
                    out_last  <= 1'b0;
                    k         <= 6'd1;
                    run       <= '0;
                    state     <= AC;
                end
                AC: if (adv) begin
                    if (cur == '0 && k != 6'd63) begin
                        out_valid <= 1'b0;
                        run       <= run + 6'd1;
                        k         <= k + 6'd1;
                    end else begin
                        out_valid <= 1'b1;
                        out_is_dc <= 1'b0;
                        if (cur == '0) begin
                            out_run   <= '0;
                            out_value <= '0;
                            out_last  <= 1'b1;
                            state     <= DRAIN;
                        end else if (run >= 6'd16) begin
                            out_run   <= 4'd15;
                            out_value <= '0;
                            out_last  <= 1'b0;
                            run       <= run - 6'd16;
                        end else begin
                            out_run   <= run[3:0];
                            out_value <= cur;
                            out_last  <= k == 6'd63;
                            run       <= '0;
                            k         <= k + 6'd1;
                            if (k == 6'd63) state <= DRAIN;
                        end
                    end
                end
                DRAIN: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// tb_zigzag_rle_encoder: directed checks of zigzag_rle_encoder symbol streams, rounding,
// backpressure stability and mid-block reset.
module tb_zigzag_rle_encoder;
    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2047:0] in_coeffs = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_run;
    logic [11:0]   out_value;
    logic          out_is_dc;
    logic          out_last;
    logic [31:0]   obs_sym;
    logic [2047:0] b1;
    logic [2047:0] b2;
    logic [2047:0] b3;
    logic [2047:0] b4;
    logic [2047:0] b5;
    int            passed = 0;
    int            total = 0;

    zigzag_rle_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeffs (in_coeffs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_run   (out_run),
        .out_value (out_value),
        .out_is_dc (out_is_dc),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    assign obs_sym = {13'b0, out_valid, out_run, out_value, out_is_dc, out_last};

    function automatic logic [31:0] sym(input logic [3:0] r, input logic [11:0] v, input logic dc, input logic l);
        return {13'b0, 1'b1, r, v, dc, l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [2047:0] blk);
        int n;
        n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", 32'(in_ready), 32'd1);
        in_coeffs = blk;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Waits for the next symbol, throttling out_ready at the given duty (percent); while stalled
    // the presented symbol must not change.
    task automatic exp_sym(input string tag, input int duty, input logic [3:0] r, input logic [11:0] v,
                           input logic dc, input logic l);
        logic [31:0] held;
        bit          stalled;
        bit          done;
        int          n;
        stalled = 0;
        done    = 0;
        n       = 0;
        held    = '0;
        while (!done) begin
            @(negedge clk);
            if (stalled) chk({tag, "_stall"}, obs_sym, held);
            if (out_valid) begin
                if ($urandom_range(99) < duty) begin
                    out_ready = 1'b1;
                    chk(tag, obs_sym, sym(r, v, dc, l));
                    done = 1;
                end else begin
                    out_ready = 1'b0;
                    held      = obs_sym;
                    stalled   = 1;
                end
            end else begin
                out_ready = $urandom_range(99) < duty;
            end
            n++;
            if (!done && n > 400) begin
                chk({tag, "_timeout"}, 32'd0, 32'd1);
                done = 1;
            end
        end
    endtask

    task automatic end_chk(input string tag);
        @(negedge clk);
        chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        b1 = '0;
        b2 = '0;
        b2[0*32 +: 32] = 32'h0005_0000;
        b2[1*32 +: 32] = 32'hFFFD_0000;
        b3 = '0;
        b3[63*32 +: 32] = 32'h0001_0000;
        b4 = '0;
        b4[0*32 +: 32]  = 32'h0001_8000;
        b4[1*32 +: 32]  = 32'hFFFF_8000;
        b4[8*32 +: 32]  = 32'hFFFE_8000;
        b4[16*32 +: 32] = 32'h0FFF_0000;
        b4[9*32 +: 32]  = 32'hF000_0000;
        b5 = '0;
        b5[55*32 +: 32] = 32'h0007_0000;
        b5[62*32 +: 32] = 32'h0009_0000;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", obs_sym, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        send(b1);
        exp_sym("t1_dc", 100, 4'd0, 12'd0, 1'b1, 1'b0);
        exp_sym("t1_eob", 100, 4'd0, 12'd0, 1'b0, 1'b1);
        end_chk("t1");

        send(b2);
        exp_sym("t2_dc", 100, 4'd0, 12'd5, 1'b1, 1'b0);
        exp_sym("t2_ac", 100, 4'd0, 12'hFFD, 1'b0, 1'b0);
        exp_sym("t2_eob", 100, 4'd0, 12'd0, 1'b0, 1'b1);
        end_chk("t2");

        send(b3);
        exp_sym("t3_dc", 100, 4'd0, 12'd0, 1'b1, 1'b0);
        exp_sym("t3_zrl0", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("t3_zrl1", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("t3_zrl2", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("t3_last", 100, 4'd14, 12'd1, 1'b0, 1'b1);
        end_chk("t3");

        send(b4);
        exp_sym("t4_dc_round_up", 100, 4'd0, 12'd2, 1'b1, 1'b0);
        exp_sym("t4_neg_half", 100, 4'd1, 12'hFFF, 1'b0, 1'b0);
        exp_sym("t4_sat_pos", 100, 4'd0, 12'h7FF, 1'b0, 1'b0);
        exp_sym("t4_sat_neg", 100, 4'd0, 12'h801, 1'b0, 1'b0);
        exp_sym("t4_eob", 100, 4'd0, 12'd0, 1'b0, 1'b1);
        end_chk("t4");

        send(b5);
        exp_sym("zz_dc", 100, 4'd0, 12'd0, 1'b1, 1'b0);
        exp_sym("zz_zrl0", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("zz_zrl1", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("zz_zrl2", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("zz_k61", 100, 4'd12, 12'd7, 1'b0, 1'b0);
        exp_sym("zz_k62", 100, 4'd0, 12'd9, 1'b0, 1'b0);
        exp_sym("zz_eob", 100, 4'd0, 12'd0, 1'b0, 1'b1);
        end_chk("zz");

        send(b2);
        exp_sym("bp2_dc", 30, 4'd0, 12'd5, 1'b1, 1'b0);
        exp_sym("bp2_ac", 30, 4'd0, 12'hFFD, 1'b0, 1'b0);
        exp_sym("bp2_eob", 30, 4'd0, 12'd0, 1'b0, 1'b1);
        end_chk("bp2");

        send(b3);
        exp_sym("bp3_dc", 30, 4'd0, 12'd0, 1'b1, 1'b0);
        exp_sym("bp3_zrl0", 30, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("bp3_zrl1", 30, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("bp3_zrl2", 30, 4'd15, 12'd0, 1'b0, 1'b0);
        exp_sym("bp3_last", 30, 4'd14, 12'd1, 1'b0, 1'b1);
        end_chk("bp3");

        send(b3);
        exp_sym("rst_dc", 100, 4'd0, 12'd0, 1'b1, 1'b0);
        exp_sym("rst_zrl0", 100, 4'd15, 12'd0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_mid_out", obs_sym, 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(b2);
        exp_sym("post_rst_dc", 100, 4'd0, 12'd5, 1'b1, 1'b0);
        exp_sym("post_rst_ac", 100, 4'd0, 12'hFFD, 1'b0, 1'b0);
        exp_sym("post_rst_eob", 100, 4'd0, 12'd0, 1'b0, 1'b1);
        end_chk("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
